// File: rtl/subline_scheduler_pkg.sv
// Shared geometry, derived widths and FSM state encoding for the subline scheduler.
package subline_scheduler_pkg;

  // Song image geometry
  localparam int CHAR_W    = 6;   // pixel columns per character
  localparam int CPSBLN    = 16;  // characters per subline
  localparam int NUM_LINES = 33;  // lyric lines in the song image
  localparam int HOLD_CYC  = 4;   // idle cycles after each non-final line (>=1)

  localparam int LINE_COLS = CHAR_W * CPSBLN;
  localparam int SONG_COLS = LINE_COLS * NUM_LINES;

  // Derived widths
  localparam int ADDR_W     = $clog2(SONG_COLS);
  localparam int COL_W      = (CHAR_W > 1)    ? $clog2(CHAR_W)    : 1;
  localparam int CHAR_IDX_W = (CPSBLN > 1)    ? $clog2(CPSBLN)    : 1;
  localparam int LINE_W     = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam int HOLD_W     = (HOLD_CYC > 1)  ? $clog2(HOLD_CYC)  : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/subline_scheduler_if.sv
// Control and ROM-side bus of the subline scheduler.
// master drives run control and observes the ROM sequencing; slave is the scheduler.
interface subline_scheduler_if;
  import subline_scheduler_pkg::*;

  logic                  start;
  logic                  pause;
  logic                  step;
  logic                  rom_en;
  logic [ADDR_W-1:0]     rom_addr;
  logic [COL_W-1:0]      col_idx;
  logic [CHAR_IDX_W-1:0] char_idx;
  logic [LINE_W-1:0]     line_idx;
  logic                  line_end;
  logic                  song_end;
  logic                  busy;

  modport master (
    output start, pause, step,
    input  rom_en, rom_addr, col_idx, char_idx, line_idx, line_end, song_end, busy
  );

  modport slave (
    input  start, pause, step,
    output rom_en, rom_addr, col_idx, char_idx, line_idx, line_end, song_end, busy
  );

endinterface

// File: rtl/subline_scheduler_wrap_counter.sv
// Modulo-MOD up-counter with synchronous clear; carry flags the wrap from MOD-1 to 0.
module subline_scheduler_wrap_counter #(
  parameter int MOD = 2,
  parameter int W   = (MOD > 1) ? $clog2(MOD) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         carry
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic         at_max;

  assign at_max = (count_q == W'(MOD - 1));
  assign carry  = en && at_max;
  assign count  = count_q;

  // Next count: clear wins, otherwise step and wrap at MOD-1
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = at_max ? '0 : count_q + W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/subline_scheduler.sv
// Subline scheduler: walks column/char/line positions of the song image, drives the
// shared ROM address and enable, and strobes line and song boundaries.
// The pos_* counters hold the column to be read next; the output registers show the
// column being read in the cycle rom_en is high.
module subline_scheduler
  import subline_scheduler_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  subline_scheduler_if.slave bus
);

  state_e state_q, state_d;

  logic adv;
  logic read_go;
  logic start_go;
  logic hold_en;

  logic col_carry, char_carry, line_carry, hold_carry;

  logic [COL_W-1:0]      pos_col;
  logic [CHAR_IDX_W-1:0] pos_char;
  logic [LINE_W-1:0]     pos_line;
  // Hold length is taken from the carry; the count value itself is not needed.
  logic [HOLD_W-1:0]     hold_cnt_unused;

  logic [ADDR_W-1:0] pos_addr_q, pos_addr_d;

  logic                  rom_en_q,   rom_en_d;
  logic [ADDR_W-1:0]     rom_addr_q, rom_addr_d;
  logic [COL_W-1:0]      col_q,      col_d;
  logic [CHAR_IDX_W-1:0] char_q,     char_d;
  logic [LINE_W-1:0]     line_q,     line_d;
  logic                  line_end_q, line_end_d;
  logic                  song_end_q, song_end_d;
  logic                  busy_q,     busy_d;

  // A step only matters while paused; without pause every RUN cycle advances once.
  assign adv      = !bus.pause || bus.step;
  assign read_go  = (state_q == S_RUN) && adv;
  assign start_go = ((state_q == S_IDLE) || (state_q == S_DONE)) && bus.start;
  assign hold_en  = (state_q == S_HOLD) && !bus.pause;

  subline_scheduler_wrap_counter #(.MOD(CHAR_W), .W(COL_W)) u_col (
    .clk(clk), .rst(rst), .clr(start_go), .en(read_go),
    .count(pos_col), .carry(col_carry)
  );

  subline_scheduler_wrap_counter #(.MOD(CPSBLN), .W(CHAR_IDX_W)) u_char (
    .clk(clk), .rst(rst), .clr(start_go), .en(col_carry),
    .count(pos_char), .carry(char_carry)
  );

  subline_scheduler_wrap_counter #(.MOD(NUM_LINES), .W(LINE_W)) u_line (
    .clk(clk), .rst(rst), .clr(start_go), .en(char_carry),
    .count(pos_line), .carry(line_carry)
  );

  subline_scheduler_wrap_counter #(.MOD(HOLD_CYC), .W(HOLD_W)) u_hold (
    .clk(clk), .rst(rst), .clr(start_go), .en(hold_en),
    .count(hold_cnt_unused), .carry(hold_carry)
  );

  // Next state: char_carry marks the last column of a line, line_carry the last of the song
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (bus.start) state_d = S_RUN;
      S_RUN:          if (char_carry) state_d = line_carry ? S_DONE : S_HOLD;
      S_HOLD:         if (hold_carry) state_d = S_RUN;
      default:        state_d = S_IDLE;
    endcase
  end

  // Linear ROM address tracks the position counters by increment
  always_comb begin
    pos_addr_d = pos_addr_q;
    if (start_go || line_carry) begin
      pos_addr_d = '0;
    end else if (read_go) begin
      pos_addr_d = pos_addr_q + ADDR_W'(1);
    end
  end

  // Registered outputs: show the column read this cycle, or the upcoming line during HOLD
  always_comb begin
    rom_en_d   = 1'b0;
    line_end_d = 1'b0;
    song_end_d = 1'b0;
    rom_addr_d = rom_addr_q;
    col_d      = col_q;
    char_d     = char_q;
    line_d     = line_q;
    if (start_go) begin
      rom_addr_d = '0;
      col_d      = '0;
      char_d     = '0;
      line_d     = '0;
    end else if (read_go) begin
      rom_en_d   = 1'b1;
      rom_addr_d = pos_addr_q;
      col_d      = pos_col;
      char_d     = pos_char;
      line_d     = pos_line;
      line_end_d = char_carry;
      song_end_d = line_carry;
    end else if (state_q == S_HOLD) begin
      rom_addr_d = pos_addr_q;
      col_d      = pos_col;
      char_d     = pos_char;
      line_d     = pos_line;
    end
    busy_d = (state_d == S_RUN) || (state_d == S_HOLD) || rom_en_d;
  end

  // State, address tracker and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pos_addr_q <= '0;
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
      col_q      <= '0;
      char_q     <= '0;
      line_q     <= '0;
      line_end_q <= 1'b0;
      song_end_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_addr_q <= pos_addr_d;
      rom_en_q   <= rom_en_d;
      rom_addr_q <= rom_addr_d;
      col_q      <= col_d;
      char_q     <= char_d;
      line_q     <= line_d;
      line_end_q <= line_end_d;
      song_end_q <= song_end_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.rom_en   = rom_en_q;
  assign bus.rom_addr = rom_addr_q;
  assign bus.col_idx  = col_q;
  assign bus.char_idx = char_q;
  assign bus.line_idx = line_q;
  assign bus.line_end = line_end_q;
  assign bus.song_end = song_end_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_subline_scheduler.sv
// Bench for subline_scheduler: directed scenarios plus random run control, every cycle
// compared against a position/phase model of the scheduler.
module tb_subline_scheduler;

  localparam int T_CHAR_W    = 6;
  localparam int T_CPSBLN    = 16;
  localparam int T_NUM_LINES = 33;
  localparam int T_HOLD_CYC  = 4;
  localparam int T_LINE_COLS = T_CHAR_W * T_CPSBLN;
  localparam int T_SONG_COLS = T_LINE_COLS * T_NUM_LINES;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HOLD = 2;
  localparam int M_DONE = 3;

  logic clk = 1'b0;
  logic rst;

  subline_scheduler_if bus ();

  subline_scheduler dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: phase, next column to read, remaining hold cycles, expected outputs
  int m_state = M_IDLE;
  int m_p     = 0;
  int m_hold  = 0;
  int e_en    = 0;
  int e_addr  = 0;
  int e_le    = 0;
  int e_se    = 0;
  int e_busy  = 0;
  int se_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0d expected %0d at t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_state = M_IDLE; m_p = 0; m_hold = 0;
      e_en = 0; e_addr = 0; e_le = 0; e_se = 0; e_busy = 0;
      return;
    end
    e_en = 0; e_le = 0; e_se = 0;
    case (m_state)
      M_IDLE, M_DONE: begin
        if (bus.start) begin
          m_state = M_RUN; m_p = 0; e_addr = 0; e_busy = 1;
        end else begin
          e_busy = 0;
        end
      end
      M_RUN: begin
        e_busy = 1;
        if (!bus.pause || bus.step) begin
          e_en   = 1;
          e_addr = m_p;
          e_le   = ((m_p % T_LINE_COLS) == T_LINE_COLS - 1) ? 1 : 0;
          e_se   = (m_p == T_SONG_COLS - 1) ? 1 : 0;
          m_p++;
          if (e_se != 0) m_state = M_DONE;
          else if (e_le != 0) begin
            m_state = M_HOLD;
            m_hold  = T_HOLD_CYC;
          end
        end
      end
      default: begin
        e_busy = 1;
        e_addr = m_p;
        if (!bus.pause) begin
          m_hold--;
          if (m_hold == 0) m_state = M_RUN;
        end
      end
    endcase
  endtask

  // One clock: advance the model on the edge, compare all outputs just after it
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    if (bus.song_end === 1'b1) se_cnt++;
    check("rom_en",   32'(bus.rom_en),   32'(e_en));
    check("rom_addr", 32'(bus.rom_addr), 32'(e_addr));
    check("col_idx",  32'(bus.col_idx),  32'(e_addr % T_CHAR_W));
    check("char_idx", 32'(bus.char_idx), 32'((e_addr / T_CHAR_W) % T_CPSBLN));
    check("line_idx", 32'(bus.line_idx), 32'(e_addr / T_LINE_COLS));
    check("line_end", 32'(bus.line_end), 32'(e_le));
    check("song_end", 32'(bus.song_end), 32'(e_se));
    check("busy",     32'(bus.busy),     32'(e_busy));
  endtask

  // Run until the DUT shows a read of the given address, bounded
  task automatic wait_addr(input int a, input int limit);
    int hit;
    hit = 0;
    for (int i = 0; i < limit && hit == 0; i++) begin
      tick();
      if (bus.rom_en === 1'b1 && int'(bus.rom_addr) == a) hit = 1;
    end
    check($sformatf("reach_addr_%0d", a), 32'(hit), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.step  = 1'b0;

    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Full song, free running, stray start pulses inside lines are ignored
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    se_cnt = 0;
    for (int i = 0; i < 4000 && m_state != M_DONE; i++) begin
      bus.start = ((i % 97) == 50) && (i < 3000);
      tick();
    end
    bus.start = 1'b0;
    repeat (3) tick();
    check("song_end_count", 32'(se_cnt), 32'd1);
    check("done_not_busy", 32'(bus.busy), 32'd0);

    // Restart from DONE, then pause at 10 with two steps
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    wait_addr(10, 20);
    bus.pause = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus.step = (k == 1 || k == 3);
      tick();
    end
    bus.step = 1'b0; bus.pause = 1'b0;
    tick();
    check("resume_addr", 32'(bus.rom_addr), 32'd13);

    // start in RUN is ignored
    wait_addr(40, 40);
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    check("start_ignored_addr", 32'(bus.rom_addr), 32'd41);

    // Mid-song reset
    wait_addr(200, 250);
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst_line_end", 32'(bus.line_end), 32'd0);
    tick();

    // start together with pause from IDLE: RUN entered, address 0 held
    bus.pause = 1'b1; bus.start = 1'b1; tick(); bus.start = 1'b0;
    repeat (3) tick();
    bus.pause = 1'b0;
    tick();
    check("first_read_addr", 32'(bus.rom_addr), 32'd0);
    repeat (5) tick();

    // Random run control
    for (int i = 0; i < 9000; i++) begin
      rst       = ($urandom_range(0, 2999) == 0);
      bus.pause = ($urandom_range(0, 3) == 0);
      bus.step  = ($urandom_range(0, 2) == 0);
      bus.start = ($urandom_range(0, 39) == 0);
      tick();
    end
    rst = 1'b0; bus.pause = 1'b0; bus.step = 1'b0; bus.start = 1'b0;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
